// File: rtl/hall_speed_meter.sv
// -----------------------------------------------------------------------------
// hall_speed_meter
//
// Measures the time between accepted falling edges of an active-low hall
// sensor and converts that period into speed = SCALE / gap. The design runs
// from a single clock. A prescaler enable defines the measurement tick, and an
// iterative restoring divider does the division one quotient bit per cycle.
//
// Edge handling:
//   - The raw input is synchronised and then edge-detected.
//   - After an accepted edge, a lockout window (in ticks) rejects sensor
//     bounce.
//   - The first accepted edge after reset or after a stall only primes the
//     meter. Each accepted edge after that produces one measurement.
//   - If TIMEOUT ticks pass without an accepted edge, the meter reports
//     speed 0 and flags stall.
//
// Optional build macro:
//   HALL_AVG_EN  When defined, the divisor is the mean of the last four gaps
//                instead of the latest gap alone.
//
// Ports:
//   clk0        in   system clock; all logic on its rising edge
//   rst_n       in   asynchronous active-low reset
//   in          in   raw hall sensor, active low, asynchronous to clk0
//   speed       out  [WIDTH] last computed speed
//   speed_valid out  one-cycle strobe when speed updates
//   gap         out  [WIDTH] last measured period in ticks (raw, unaveraged)
//   stalled     out  high while no pulse was seen within TIMEOUT ticks
//   busy        out  divider running
//   pulse_cnt   out  [WIDTH] number of accepted edges, wraps
// -----------------------------------------------------------------------------
module hall_speed_meter #(
  parameter int WIDTH   = 16,
  parameter int CLK_DIV = 5000,
  parameter int LOCKOUT = 500,
  parameter int TIMEOUT = 20000,
  parameter int SCALE   = 10000
) (
  input  logic             clk0,
  input  logic             rst_n,
  input  logic             in,
  output logic [WIDTH-1:0] speed,
  output logic             speed_valid,
  output logic [WIDTH-1:0] gap,
  output logic             stalled,
  output logic             busy,
  output logic [WIDTH-1:0] pulse_cnt
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int LW = (LOCKOUT > 0) ? $clog2(LOCKOUT + 1) : 1;
  localparam int BW = $clog2(WIDTH + 1);

  localparam logic [PW-1:0]    PRE_LAST  = PW'(CLK_DIV - 1);
  localparam logic [LW-1:0]    LOCK_LOAD = LW'(LOCKOUT);
  localparam logic [WIDTH-1:0] TMO_VAL   = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] DIVIDEND  = WIDTH'(SCALE);
  localparam logic [BW-1:0]    DIV_STEPS = BW'(WIDTH);

  // Saturating increment for the tick-based gap counter.
  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (v == {WIDTH{1'b1}}) ? v : v + WIDTH'(1);
  endfunction

  // One restoring-division step. The partial remainder shifts in the next
  // dividend bit from the top of the quotient register. The new quotient bit
  // enters at the bottom. Returns {remainder, quotient}.
  function automatic logic [2*WIDTH-1:0] div_step(
    input logic [WIDTH-1:0] rem,
    input logic [WIDTH-1:0] quo,
    input logic [WIDTH-1:0] dvs
  );
    logic [WIDTH:0]   sh;
    logic [WIDTH-1:0] diff;
    sh   = {rem, quo[WIDTH-1]};
    diff = WIDTH'(sh - {1'b0, dvs});
    if (sh >= {1'b0, dvs}) begin
      return {diff, quo[WIDTH-2:0], 1'b1};
    end else begin
      return {sh[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
    end
  endfunction

  // Prescaler and input conditioning
  logic [PW-1:0]    r_pre;
  logic             w_tick;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_sync_prev;
  logic             w_fall;
  logic [LW-1:0]    r_lock;
  logic             w_accept;
  logic [WIDTH-1:0] r_gcnt;

  // Measurement control and divider
  logic             r_primed;
  logic             r_stalled;
  logic             r_busy;
  logic             r_speed_valid;
  logic [WIDTH-1:0] r_speed;
  logic [WIDTH-1:0] r_gap;
  logic [WIDTH-1:0] r_pulse_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [BW-1:0]    r_bits;
  logic [2*WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_divisor;
  logic             w_measure;
  logic             w_timeout;

  assign w_tick = (r_pre == PRE_LAST);

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  // The sensor idles high. The synchroniser resets to 1 so that leaving
  // reset never looks like a falling edge.
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_sync_prev <= 1'b1;
    end else begin
      r_sync1     <= in;
      r_sync2     <= r_sync1;
      r_sync_prev <= r_sync2;
    end
  end

  assign w_fall   = r_sync_prev & ~r_sync2;
  assign w_accept = w_fall && (r_lock == '0);

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      r_lock <= '0;
    end else if (w_accept) begin
      r_lock <= LOCK_LOAD;
    end else if (w_tick && (r_lock != '0)) begin
      r_lock <= r_lock - LW'(1);
    end
  end

  // An accepted edge restarts the count. A tick in that same cycle is
  // dropped, so the gap counts whole ticks strictly between the two edges.
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      r_gcnt <= '0;
    end else if (w_accept) begin
      r_gcnt <= '0;
    end else if (w_tick) begin
      r_gcnt <= sat_inc(r_gcnt);
    end
  end

  assign w_measure = w_accept && r_primed;
  // An edge in the same cycle wins over the timeout. Gating with the stall
  // flag makes the timeout fire once per stall. It also keeps the timeout
  // quiet while the meter sits unprimed after reset.
  assign w_timeout = !w_accept && !r_stalled && (r_gcnt == TMO_VAL);

`ifdef HALL_AVG_EN
  logic [WIDTH-1:0] r_hist [4];
  logic             r_hist_vld;
  logic [WIDTH+1:0] w_sum;

  // The sum uses the new gap plus the three newest stored gaps. The oldest
  // slot is about to be shifted out. The first measurement fills every slot
  // with the same gap, so its average is the gap itself.
  always_comb begin
    w_sum = {r_gcnt, 2'b00};
    if (r_hist_vld) begin
      w_sum = {2'b00, r_gcnt} + {2'b00, r_hist[0]} +
              {2'b00, r_hist[1]} + {2'b00, r_hist[2]};
    end
  end

  assign w_divisor = WIDTH'(w_sum >> 2);

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      r_hist_vld <= 1'b0;
      for (int i = 0; i < 4; i++) r_hist[i] <= '0;
    end else if (w_measure) begin
      r_hist_vld <= 1'b1;
      if (!r_hist_vld) begin
        for (int i = 0; i < 4; i++) r_hist[i] <= r_gcnt;
      end else begin
        r_hist[0] <= r_gcnt;
        r_hist[1] <= r_hist[0];
        r_hist[2] <= r_hist[1];
        r_hist[3] <= r_hist[2];
      end
    end else if (w_timeout) begin
      r_hist_vld <= 1'b0;
      for (int i = 0; i < 4; i++) r_hist[i] <= '0;
    end
  end
`else
  assign w_divisor = r_gcnt;
`endif

  assign w_step = div_step(r_rem, r_quo, r_dvs);

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      r_primed      <= 1'b0;
      r_stalled     <= 1'b1;
      r_busy        <= 1'b0;
      r_speed_valid <= 1'b0;
      r_speed       <= '0;
      r_gap         <= '0;
      r_pulse_cnt   <= '0;
      r_rem         <= '0;
      r_quo         <= '0;
      r_dvs         <= '0;
      r_bits        <= '0;
    end else begin
      r_speed_valid <= 1'b0;

      if (w_accept) begin
        r_pulse_cnt <= r_pulse_cnt + WIDTH'(1);
        if (!r_primed) begin
          r_primed  <= 1'b1;
          r_stalled <= 1'b0;
        end
      end

      if (w_measure) begin
        // A new measurement discards any divide still in flight.
        r_gap  <= r_gcnt;
        r_dvs  <= w_divisor;
        r_rem  <= '0;
        r_quo  <= DIVIDEND;
        r_bits <= DIV_STEPS;
        r_busy <= 1'b1;
      end else if (w_timeout) begin
        r_busy        <= 1'b0;
        r_bits        <= '0;
        r_speed       <= '0;
        r_speed_valid <= 1'b1;
        r_stalled     <= 1'b1;
        r_primed      <= 1'b0;
      end else if (r_busy) begin
        r_rem  <= w_step[2*WIDTH-1:WIDTH];
        r_quo  <= w_step[WIDTH-1:0];
        r_bits <= r_bits - BW'(1);
        if (r_bits == BW'(1)) begin
          r_busy        <= 1'b0;
          r_speed       <= w_step[WIDTH-1:0];
          r_speed_valid <= 1'b1;
        end
      end
    end
  end

  assign speed       = r_speed;
  assign speed_valid = r_speed_valid;
  assign gap         = r_gap;
  assign stalled     = r_stalled;
  assign busy        = r_busy;
  assign pulse_cnt   = r_pulse_cnt;

endmodule
